// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: state encoding and
// default widths/timeouts.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DATA  = 2'd1,
    ARB_INSTR = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state timer: counts grant cycles without an ack and flags the cycle in
// which the MAX_WAIT-th such cycle is reached. MAX_WAIT = 0 disables it.
module mem_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  logic [CNT_W-1:0] r_cnt;

  // Count un-acked cycles; saturate at the terminal value so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != TERM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (MAX_WAIT > 0) && en && (r_cnt == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM
// stage. Data accesses win (older instruction); a wait-state timeout completes
// a hung access with zero data and a one-cycle bus_err.
//
//   state     | meaning
//   ARB_IDLE  | no access outstanding, mem_req low
//   ARB_DATA  | MEM-stage load/store owns the port
//   ARB_INSTR | instruction fetch owns the port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_pipe,
  output logic              bus_err
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_dm_any;
  logic w_busy;
  logic w_timeout;
  logic w_done;
  logic w_grant_data;
  logic w_grant_instr;

  assign w_dm_any = dm_rd | dm_wr;
  assign w_busy   = (r_state != ARB_IDLE);
  assign w_done   = w_busy & (mem_ack | w_timeout);

  // Timer is cleared on every grant so back-to-back accesses each get a full budget.
  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_grant_data | w_grant_instr),
    .en      (w_busy & ~mem_ack),
    .expired (w_timeout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and grant decode; the requester just served is never re-granted.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_data  = 1'b0;
    w_grant_instr = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_dm_any) begin
          w_state_nxt  = ARB_DATA;
          w_grant_data = 1'b1;
        end else if (if_req) begin
          w_state_nxt   = ARB_INSTR;
          w_grant_instr = 1'b1;
        end
      end
      ARB_DATA: begin
        if (w_done) begin
          if (if_req) begin
            w_state_nxt   = ARB_INSTR;
            w_grant_instr = 1'b1;
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end
      end
      ARB_INSTR: begin
        if (w_done) begin
          if (w_dm_any) begin
            w_state_nxt  = ARB_DATA;
            w_grant_data = 1'b1;
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Memory-side request registers, loaded at each grant and dropped on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_data) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= dm_wr;
      r_mem_addr  <= dm_addr;
      r_mem_wdata <= dm_wdata;
    end else if (w_grant_instr) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= if_addr;
      r_mem_wdata <= '0;
    end else if (w_done) begin
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  assign if_valid = (r_state == ARB_INSTR) & w_done;
  assign dm_valid = (r_state == ARB_DATA) & w_done;
  assign if_rdata = (if_valid & mem_ack) ? mem_rdata : '0;
  assign dm_rdata = (dm_valid & mem_ack) ? mem_rdata : '0;
  assign bus_err  = w_timeout;

  assign stall_pipe = w_dm_any & ~dm_valid;
  assign stall_if   = if_req & ~if_valid;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between instruction fetch (IF stage) and data access (MEM stage) in the 5-stage pipeline. A 3-state FSM grants one requester at a time and drives a req/ack memory handshake. It raises stall signals alongside the load-use hazard logic, and a wait-state timeout prevents pipeline deadlock.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_WAIT, 15, max cycles mem_req may wait for mem_ack before timeout; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
if_req  in  1  IF fetch request; held until if_valid
if_addr  in  ADDR_W  fetch address; stable while if_req
if_valid  out  1  fetch complete this cycle
if_rdata  out  DATA_W  fetched instruction; valid with if_valid
dm_rd  in  1  MEM-stage load request; held until dm_valid
dm_wr  in  1  MEM-stage store request; held until dm_valid
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_valid  out  1  data access complete this cycle
dm_rdata  out  DATA_W  load data; valid with dm_valid
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write, registered
mem_addr  out  ADDR_W  registered at grant
mem_wdata  out  DATA_W  registered at grant
mem_ack  in  1  memory completes the access this cycle
mem_rdata  in  DATA_W  read data, valid with mem_ack
stall_if  out  1  freeze PC and IF/ID; bubble into ID/EX
stall_pipe  out  1  freeze the whole pipeline
bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Clock: single clock clk. Reset: synchronous, active-low, on rst_n.
- Reset (any rst_n=0 edge, including mid-transaction): state IDLE; mem_req, mem_we, bus_err, wait counter = 0; mem_addr and mem_wdata = 0. Outstanding access is abandoned; the memory must tolerate mem_req dropping.
- States: IDLE, DATA, INSTR.
- IDLE: if (dm_rd|dm_wr) -> DATA; else if if_req -> INSTR. Data always wins because the MEM stage is older.
- On grant edge: mem_req<=1; mem_we<=dm_wr (DATA) or 0 (INSTR); mem_addr/mem_wdata latched from the granted requester. Wait counter cleared.
- DATA/INSTR: mem_req stays high, outputs stable until completion.
- Completion: mem_ack=1, or timeout.
  - Combinationally in that cycle: granted *_valid=1; *_rdata=mem_rdata, or 0 on timeout.
  - The served requester's req is still high in that cycle and must be ignored.
- Next state after DATA completes: INSTR if if_req, else IDLE. After INSTR completes: DATA if dm_rd|dm_wr, else IDLE.
- Back-to-back grant re-registers the address and keeps mem_req high with no idle cycle. Otherwise mem_req<=0.
- mem_ack in the first mem_req cycle is legal (1-cycle access). Minimum request-to-valid latency: 1 cycle. mem_ack while mem_req=0 is ignored.
- Timeout (MAX_WAIT>0): counter increments each grant-state cycle without ack. It fires in the MAX_WAIT-th cycle mem_req is high without ack. On firing: completes as above with rdata=0, and bus_err=1 for that cycle only. Counter width = clog2(MAX_WAIT+1).
- dm_rd & dm_wr both high: illegal, treated as a write; the bench asserts it never occurs.
- Stalls (combinational):
  - stall_pipe = (dm_rd|dm_wr) & ~dm_valid.
  - stall_if = if_req & ~if_valid.
  - Both may be high together; stall_pipe dominates at the pipeline.
- if_rdata and dm_rdata are 0 when their valid is 0.

Decomposition:
- Shared package: state encoding (ARB_IDLE=2'd0, ARB_DATA=2'd1, ARB_INSTR=2'd2), default ADDR_W/DATA_W, MAX_WAIT default.
- Sub-module mem_wait_timer: clear/enable/expire counter. Ports: clk, rst_n, clr, en, expired. Parameter MAX_WAIT.

Test Plan:
- Reset mid-access: grant DATA, hold rst_n=0 for 2 cycles with no ack -> mem_req=0 from first reset edge, state IDLE, bus_err=0. After release, pending if_req is granted next cycle.
- Lone fetch: if_req, if_addr=0x40 at cycle 0; mem_ack at cycle 3 with 0x8C220004 -> mem_req=1 cycles 1-3, mem_we=0, mem_addr=0x40. if_valid=1 and if_rdata=0x8C220004 at cycle 3; stall_if=1 cycles 0-2.
- Contention: if_req (0x44) and dm_rd (0x200) at cycle 0, ack with 1 wait each -> mem_addr=0x200 first. Then mem_addr=0x44 directly after dm_valid, mem_req never drops; stall_pipe=1 until dm_valid.
- Store: dm_wr, dm_addr=0x100, dm_wdata=0xDEADBEEF, ack in first mem_req cycle -> mem_we=1, mem_wdata=0xDEADBEEF; dm_valid=1 in cycle 1; dm_rdata=0.
- Timeout: MAX_WAIT=4, dm_rd, never ack -> dm_valid=1, dm_rdata=0, bus_err=1 in the 4th mem_req cycle. bus_err=0 in the next cycle, FSM returns to IDLE.
- Served-requester exclusion: if_req held high during its ack cycle, no dm request -> next state IDLE, not a duplicate fetch of the same address.
